// File: rtl/bsg_tag_pkg.sv
// bsg_tag_pkg
//   Shared types for the bsg_tag serial transmitter.
//   - bsg_tag_tx_state_e : serializer FSM states, one emitted bit per cycle.
//   - bsg_tag_max        : constant helper used to size counters.
//   - BSG_TAG_TX_CMD_S_DECLARE(lg_els, lg_width) declares the captured
//     command struct inside a module, because its field widths depend on
//     that module's parameters.

package bsg_tag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LEN,
    DNR,
    NODE,
    PAY,
    GAP,
    RST
  } bsg_tag_tx_state_e;

  function automatic int bsg_tag_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`define BSG_TAG_TX_CMD_S_DECLARE(lg_els_mp, lg_width_mp) \
  typedef struct packed { \
    logic                              reset_cmd; \
    logic [(lg_els_mp)-1:0]            node_id; \
    logic                              data_not_reset; \
    logic [(lg_width_mp)-1:0]          len; \
    logic [(2**(lg_width_mp))-2:0]     payload; \
  } bsg_tag_tx_cmd_s;

// File: rtl/bsg_tag_tx_piso.sv
// bsg_tag_tx_piso
//   Loadable LSB-first shift register with a saturating down-counter.
//   The top level loads one field (len, node id or payload) together with
//   its bit count and then shifts it out one bit per cycle.
// Ports
//   clk_i      in   tag clock
//   reset_n_i  in   asynchronous active-low reset
//   load_i     in   load data_i/count_i (wins over shift_i)
//   data_i     in   field value, bit 0 is emitted first
//   count_i    in   number of bits in the field
//   shift_i    in   advance to the next bit
//   bit_o      out  current bit (LSB of the shift register)
//   last_o     out  current bit is the last of the field

module bsg_tag_tx_piso #(
  parameter int width_p     = 15,
  parameter int cnt_width_p = 6
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_i,
  input  logic [width_p-1:0]     data_i,
  input  logic [cnt_width_p-1:0] count_i,
  input  logic                   shift_i,
  output logic                   bit_o,
  output logic                   last_o
);

  logic [width_p-1:0]     data_q, data_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = count_i;
    end else if (shift_i) begin
      data_d = data_q >> 1;
      // Saturate at zero so an extra shift can never wrap the count.
      cnt_d  = (cnt_q == '0) ? '0 : cnt_q - cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o  = data_q[0];
  assign last_o = (cnt_q == cnt_width_p'(1));

endmodule

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag_serial_tx
//   Transmit side of the bsg_tag serial protocol. Accepts one parallel tag
//   command per valid/ready handshake and serializes it onto tag_data_o.
//   A command is either a client packet
//     start(1) len(LSB first) data_not_reset node_id(LSB first) payload[0..len-1]
//   or a master-reset burst of reset_ones_p ones. Both end with gap_zeros_p
//   zeros; done_o marks the last gap bit.
// Ports
//   clk_i, reset_n_i   tag clock, asynchronous active-low reset
//   v_i / ready_o      command handshake (ready_o is registered)
//   reset_cmd_i        1 = master-reset burst, 0 = client packet
//   node_id_i          destination client id
//   data_not_reset_i   1 = data packet, 0 = client-reset packet
//   len_i / payload_i  payload length and bits (bit 0 first)
//   tag_data_o         registered serial stream
//   done_o             registered pulse aligned with the last gap bit

module bsg_tag_serial_tx
  import bsg_tag_pkg::*;
#(
  parameter int els_p        = 64,
  parameter int lg_width_p   = 4,
  parameter int reset_ones_p = 32,
  parameter int gap_zeros_p  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic                       reset_cmd_i,
  input  logic [$clog2(els_p)-1:0]   node_id_i,
  input  logic                       data_not_reset_i,
  input  logic [lg_width_p-1:0]      len_i,
  input  logic [(2**lg_width_p)-2:0] payload_i,
  output logic                       tag_data_o,
  output logic                       done_o
);

  localparam int lg_els_lp  = $clog2(els_p);
  localparam int pay_w_lp   = (2**lg_width_p) - 1;
  localparam int piso_w_lp  = bsg_tag_max(bsg_tag_max(pay_w_lp, lg_els_lp), lg_width_p);
  localparam int cnt_w_lp   = $clog2(bsg_tag_max(bsg_tag_max(reset_ones_p, 2**lg_width_p),
                                                 bsg_tag_max(lg_els_lp, gap_zeros_p)) + 1);

  `BSG_TAG_TX_CMD_S_DECLARE(lg_els_lp, lg_width_p)

  bsg_tag_tx_state_e state_q, state_d;
  bsg_tag_tx_cmd_s   cmd_q, cmd_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d, cnt_dec;
  logic ready_q, ready_d;
  logic tag_q, tag_d;
  logic done_q, done_d;
  logic accept;

  logic                 piso_load, piso_shift, piso_bit, piso_last;
  logic [piso_w_lp-1:0] piso_data;
  logic [cnt_w_lp-1:0]  piso_count;

  // ready_q is only ever set while the FSM sits in IDLE, so accept implies IDLE.
  assign accept  = v_i & ready_q;
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - cnt_w_lp'(1);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    tag_d      = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_data  = '0;
    piso_count = '0;

    case (state_q)
      IDLE: begin
        // Registered ready drops in the cycle after acceptance.
        ready_d = ~accept;
        if (accept) begin
          cmd_d.reset_cmd      = reset_cmd_i;
          cmd_d.node_id        = node_id_i;
          cmd_d.data_not_reset = data_not_reset_i;
          cmd_d.len            = len_i;
          cmd_d.payload        = payload_i;
          if (reset_cmd_i) begin
            state_d = RST;
            cnt_d   = cnt_w_lp'(reset_ones_p);
          end else begin
            state_d = START;
          end
        end
      end

      START: begin
        tag_d      = 1'b1;
        piso_load  = 1'b1;
        piso_data  = piso_w_lp'(cmd_q.len);
        piso_count = cnt_w_lp'(lg_width_p);
        state_d    = LEN;
      end

      LEN: begin
        tag_d      = piso_bit;
        piso_shift = 1'b1;
        if (piso_last) state_d = DNR;
      end

      DNR: begin
        tag_d      = cmd_q.data_not_reset;
        piso_load  = 1'b1;
        piso_data  = piso_w_lp'(cmd_q.node_id);
        piso_count = cnt_w_lp'(lg_els_lp);
        state_d    = NODE;
      end

      NODE: begin
        tag_d      = piso_bit;
        piso_shift = 1'b1;
        if (piso_last) begin
          if (cmd_q.len == '0) begin
            state_d = GAP;
            cnt_d   = cnt_w_lp'(gap_zeros_p);
          end else begin
            // Reload while the final node bit is still on the output.
            piso_load  = 1'b1;
            piso_data  = piso_w_lp'(cmd_q.payload);
            piso_count = cnt_w_lp'(cmd_q.len);
            state_d    = PAY;
          end
        end
      end

      PAY: begin
        tag_d      = piso_bit;
        piso_shift = 1'b1;
        if (piso_last) begin
          state_d = GAP;
          cnt_d   = cnt_w_lp'(gap_zeros_p);
        end
      end

      GAP: begin
        tag_d = 1'b0;
        if (cnt_q <= cnt_w_lp'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      RST: begin
        // RST is only entered from a captured reset command, so this is a 1.
        tag_d = cmd_q.reset_cmd;
        if (cnt_q <= cnt_w_lp'(1)) begin
          state_d = GAP;
          cnt_d   = cnt_w_lp'(gap_zeros_p);
        end else begin
          cnt_d = cnt_dec;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      tag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
    end
  end

  bsg_tag_tx_piso #(
    .width_p    (piso_w_lp),
    .cnt_width_p(cnt_w_lp)
  ) piso_inst (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (piso_load),
    .data_i   (piso_data),
    .count_i  (piso_count),
    .shift_i  (piso_shift),
    .bit_o    (piso_bit),
    .last_o   (piso_last)
  );

  assign ready_o    = ready_q;
  assign tag_data_o = tag_q;
  assign done_o     = done_q;

endmodule
